// File: rtl/cadeado_pkg.sv
// Shared definitions for the combination-lock digit-entry path: FSM states,
// digit width, default code and default strobe timing.
package cadeado_pkg;

   localparam int          DIGITO_W        = 4;
   localparam int          NUM_DIGITOS_DEF = 6;
   localparam int          SETUP_CIC_DEF   = 2;
   localparam int          PULSO_CIC_DEF   = 3;
   localparam int          HOLD_CIC_DEF    = 2;
   localparam logic [23:0] CODIGO_DEF      = 24'h590981;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      PULSO = 3'd2,
      HOLD  = 3'd3,
      FIM   = 3'd4
   } estado_t;

   // Phase counter only ever holds CIC-1, so max(CIC)+1 values is plenty.
   function automatic int fase_w(input int s, input int p, input int h);
      int m;
      m = s;
      if (p > m) m = p;
      if (h > m) m = h;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/emissor_codigo_if.sv
// Digit-entry bus between the code emitter (master) and a lock or test driver
// (slave). Building with EMISSOR_ERRO_EN adds the error-injection controls.
interface emissor_codigo_if #(
   parameter int NUM_DIGITOS = cadeado_pkg::NUM_DIGITOS_DEF
);
   logic                                         start;
   logic                                         abortar;
   logic [cadeado_pkg::DIGITO_W*NUM_DIGITOS-1:0] codigo;
   logic [cadeado_pkg::DIGITO_W-1:0]             numero;
   logic                                         insere;
   logic                                         ocupado;
   logic                                         concluido;
   logic [2:0]                                   indice;
   cadeado_pkg::estado_t                         estado;
`ifdef EMISSOR_ERRO_EN
   logic [2:0]                                   erro_idx;
   logic                                         erro_ativo;
`endif

   // Handshake: start is a request taken only while ocupado=0; once taken the
   // bus is busy until the concluido pulse or an abort, and further start
   // requests are dropped. The consumer samples numero when insere falls.
`ifdef EMISSOR_ERRO_EN
   modport master (input  start, abortar, codigo, erro_idx, erro_ativo,
                   output numero, insere, ocupado, concluido, indice, estado);
   modport slave  (output start, abortar, codigo, erro_idx, erro_ativo,
                   input  numero, insere, ocupado, concluido, indice, estado);
`else
   modport master (input  start, abortar, codigo,
                   output numero, insere, ocupado, concluido, indice, estado);
   modport slave  (output start, abortar, codigo,
                   input  numero, insere, ocupado, concluido, indice, estado);
`endif

endinterface

// File: rtl/contador_fase.sv
// Loadable down-counter with terminal-count flag; times each strobe phase.
module contador_fase #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         carga_i,
   input  logic [W-1:0] valor_i,
   output logic         fim_o
);

   logic [W-1:0] cont_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cont_q <= '0;
      end else if (carga_i) begin
         cont_q <= valor_i;
      end else if (cont_q != '0) begin
         cont_q <= cont_q - 1'b1;
      end
   end

   assign fim_o = (cont_q == '0);

endmodule

// File: rtl/emissor_codigo.sv
// Code emitter: sends an N-digit BCD code MSB-first as numero/insere strobes.
// Define EMISSOR_ERRO_EN to corrupt one chosen digit and then re-send it.
module emissor_codigo
   import cadeado_pkg::*;
#(
   parameter int NUM_DIGITOS = NUM_DIGITOS_DEF,
   parameter int SETUP_CIC   = SETUP_CIC_DEF,
   parameter int PULSO_CIC   = PULSO_CIC_DEF,
   parameter int HOLD_CIC    = HOLD_CIC_DEF
) (
   input  logic             clk,
   input  logic             reset,
   emissor_codigo_if.master bus
);

   localparam int                CODIGO_W = DIGITO_W * NUM_DIGITOS;
   localparam int                FASE_W   = fase_w(SETUP_CIC, PULSO_CIC, HOLD_CIC);
   localparam logic [FASE_W-1:0] SETUP_V  = FASE_W'(SETUP_CIC - 1);
   localparam logic [FASE_W-1:0] PULSO_V  = FASE_W'(PULSO_CIC - 1);
   localparam logic [FASE_W-1:0] HOLD_V   = FASE_W'(HOLD_CIC - 1);
   localparam logic [2:0]        ULTIMO   = 3'(NUM_DIGITOS - 1);

   estado_t               estado_q;
   logic [CODIGO_W-1:0]   shift_q;
   logic [CODIGO_W-1:0]   shift_prox;
   logic [DIGITO_W-1:0]   numero_q;
   logic [DIGITO_W-1:0]   nib_ini;
   logic [DIGITO_W-1:0]   nib_prox;
   logic [DIGITO_W-1:0]   nib_atual;
   logic                  insere_q;
   logic                  ocupado_q;
   logic                  concluido_q;
   logic [2:0]            indice_q;
   logic                  carga_d;
   logic [FASE_W-1:0]     valor_d;
   logic                  fase_fim;
   logic                  corromper_ini;
   logic                  corromper_prox;
   logic                  reenviar;

   assign shift_prox = shift_q << DIGITO_W;
   assign nib_ini    = bus.codigo[CODIGO_W-1 -: DIGITO_W];
   assign nib_prox   = shift_prox[CODIGO_W-1 -: DIGITO_W];
   assign nib_atual  = shift_q[CODIGO_W-1 -: DIGITO_W];

   // Reload the phase counter on every phase entry.
   always_comb begin
      carga_d = 1'b0;
      valor_d = '0;
      case (estado_q)
         IDLE:    if (bus.start) begin carga_d = 1'b1; valor_d = SETUP_V; end
         SETUP:   if (fase_fim)  begin carga_d = 1'b1; valor_d = PULSO_V; end
         PULSO:   if (fase_fim)  begin carga_d = 1'b1; valor_d = HOLD_V;  end
         HOLD:    if (fase_fim)  begin carga_d = 1'b1; valor_d = SETUP_V; end
         default: ;
      endcase
   end

   contador_fase #(.W(FASE_W)) u_fase (
      .clk     (clk),
      .reset   (reset),
      .carga_i (carga_d),
      .valor_i (valor_d),
      .fim_o   (fase_fim)
   );

`ifdef EMISSOR_ERRO_EN
   logic [2:0] erro_idx_q;
   logic       erro_pend_q;
   logic       corrompido_q;

   assign corromper_ini  = bus.erro_ativo && (bus.erro_idx == 3'd0);
   assign corromper_prox = erro_pend_q && (erro_idx_q == indice_q + 3'd1);
   assign reenviar       = corrompido_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         erro_idx_q   <= '0;
         erro_pend_q  <= 1'b0;
         corrompido_q <= 1'b0;
      end else if (estado_q == IDLE && bus.start) begin
         erro_idx_q   <= bus.erro_idx;
         erro_pend_q  <= bus.erro_ativo && !corromper_ini;
         corrompido_q <= corromper_ini;
      end else if (estado_q == HOLD && fase_fim && !bus.abortar) begin
         if (corrompido_q) begin
            corrompido_q <= 1'b0;
         end else if (corromper_prox && indice_q != ULTIMO) begin
            corrompido_q <= 1'b1;
            erro_pend_q  <= 1'b0;
         end
      end
   end
`else
   assign corromper_ini  = 1'b0;
   assign corromper_prox = 1'b0;
   assign reenviar       = 1'b0;
`endif

   // numero only moves on SETUP entry or exit to IDLE/FIM, so it is always
   // stable around the insere edges.
   always_ff @(posedge clk) begin
      if (!reset) begin
         estado_q    <= IDLE;
         shift_q     <= '0;
         numero_q    <= '0;
         insere_q    <= 1'b1;
         ocupado_q   <= 1'b0;
         concluido_q <= 1'b0;
         indice_q    <= '0;
      end else if (estado_q != IDLE && bus.abortar) begin
         estado_q    <= IDLE;
         numero_q    <= '0;
         insere_q    <= 1'b1;
         ocupado_q   <= 1'b0;
         concluido_q <= 1'b0;
         indice_q    <= '0;
      end else begin
         concluido_q <= 1'b0;
         case (estado_q)
            IDLE: begin
               if (bus.start) begin
                  shift_q   <= bus.codigo;
                  indice_q  <= '0;
                  numero_q  <= corromper_ini ? ~nib_ini : nib_ini;
                  ocupado_q <= 1'b1;
                  estado_q  <= SETUP;
               end
            end
            SETUP: begin
               if (fase_fim) begin
                  insere_q <= 1'b0;
                  estado_q <= PULSO;
               end
            end
            PULSO: begin
               if (fase_fim) begin
                  insere_q <= 1'b1;
                  estado_q <= HOLD;
               end
            end
            HOLD: begin
               if (fase_fim) begin
                  if (reenviar) begin
                     numero_q <= nib_atual;
                     estado_q <= SETUP;
                  end else if (indice_q == ULTIMO) begin
                     numero_q    <= '0;
                     concluido_q <= 1'b1;
                     estado_q    <= FIM;
                  end else begin
                     shift_q  <= shift_prox;
                     indice_q <= indice_q + 3'd1;
                     numero_q <= corromper_prox ? ~nib_prox : nib_prox;
                     estado_q <= SETUP;
                  end
               end
            end
            FIM: begin
               ocupado_q <= 1'b0;
               estado_q  <= IDLE;
            end
            default: estado_q <= IDLE;
         endcase
      end
   end

   assign bus.numero    = numero_q;
   assign bus.insere    = insere_q;
   assign bus.ocupado   = ocupado_q;
   assign bus.concluido = concluido_q;
   assign bus.indice    = indice_q;
   assign bus.estado    = estado_q;

endmodule

// File: tb/tb_emissor_codigo.sv
// Directed bench for emissor_codigo: per-digit vector table plus sequences
// for abort, mid-transfer reset, ignored start and back-to-back transfers.
module tb_emissor_codigo;
   import cadeado_pkg::*;

   logic clk;
   logic reset;

   emissor_codigo_if #(.NUM_DIGITOS(6)) bus ();

   emissor_codigo #(
      .NUM_DIGITOS (6),
      .SETUP_CIC   (2),
      .PULSO_CIC   (3),
      .HOLD_CIC    (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [23:0] codigo;
      logic [2:0]  indice;
      logic [3:0]  numero;
   } vetor_t;

   vetor_t     tab [18];
   int         total;
   int         passou;
   int         viol;
   bit         mon_en;
   logic [3:0] num_ant;
   logic       ins_ant;
   logic [3:0] exp_q [$];
   logic [3:0] got_q [$];

   // Watches every cycle for numero moving around a low strobe and records
   // the digit seen at each falling edge of insere.
   always @(negedge clk) begin
      if (mon_en) begin
         if ((ins_ant == 1'b0 || bus.insere != ins_ant) && bus.numero != num_ant) viol++;
         if (ins_ant == 1'b1 && bus.insere == 1'b0) got_q.push_back(bus.numero);
      end
      num_ant = bus.numero;
      ins_ant = bus.insere;
   end

   task automatic confere(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      total++;
      if (atual === esperado) passou++;
      else $display("FAIL %s: got %h expected %h", nome, atual, esperado);
   endtask

   task automatic passo();
      @(negedge clk);
   endtask

   task automatic pulso_start(input logic [23:0] c);
      bus.codigo = c;
      bus.start  = 1'b1;
      passo();
      bus.start  = 1'b0;
   endtask

   // Called in the first cycle after acceptance; n ends as that cycle's number.
   task automatic espera_fim(output int n);
      n = 1;
      while (bus.concluido !== 1'b1 && n < 200) begin
         passo();
         n++;
      end
   endtask

   task automatic confere_fila(input string nome);
      confere({nome, "_n"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         confere($sformatf("%s_%0d", nome, i), 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic espera_590981();
      exp_q.push_back(4'h5); exp_q.push_back(4'h9); exp_q.push_back(4'h0);
      exp_q.push_back(4'h9); exp_q.push_back(4'h8); exp_q.push_back(4'h1);
   endtask

   initial begin
      int n;
      int k;
      total  = 0;
      passou = 0;
      viol   = 0;
      mon_en = 1'b0;

      tab[0]  = '{24'h590981, 3'd0, 4'h5};
      tab[1]  = '{24'h590981, 3'd1, 4'h9};
      tab[2]  = '{24'h590981, 3'd2, 4'h0};
      tab[3]  = '{24'h590981, 3'd3, 4'h9};
      tab[4]  = '{24'h590981, 3'd4, 4'h8};
      tab[5]  = '{24'h590981, 3'd5, 4'h1};
      tab[6]  = '{24'hFA0C3B, 3'd0, 4'hF};
      tab[7]  = '{24'hFA0C3B, 3'd1, 4'hA};
      tab[8]  = '{24'hFA0C3B, 3'd2, 4'h0};
      tab[9]  = '{24'hFA0C3B, 3'd3, 4'hC};
      tab[10] = '{24'hFA0C3B, 3'd4, 4'h3};
      tab[11] = '{24'hFA0C3B, 3'd5, 4'hB};
      tab[12] = '{24'h7E1D24, 3'd0, 4'h7};
      tab[13] = '{24'h7E1D24, 3'd1, 4'hE};
      tab[14] = '{24'h7E1D24, 3'd2, 4'h1};
      tab[15] = '{24'h7E1D24, 3'd3, 4'hD};
      tab[16] = '{24'h7E1D24, 3'd4, 4'h2};
      tab[17] = '{24'h7E1D24, 3'd5, 4'h4};

      reset       = 1'b0;
      bus.start   = 1'b0;
      bus.abortar = 1'b0;
      bus.codigo  = '0;
`ifdef EMISSOR_ERRO_EN
      bus.erro_idx   = 3'd0;
      bus.erro_ativo = 1'b0;
`endif
      passo();
      passo();
      confere("reset", {bus.numero, bus.insere, bus.ocupado, bus.concluido, bus.indice},
              {4'h0, 1'b1, 1'b0, 1'b0, 3'd0});
      reset  = 1'b1;
      passo();
      mon_en = 1'b1;

      // Cycle-exact waveform for each digit: 2 setup, 3 strobe-low, 2 hold.
      for (int r = 0; r < 18; r++) begin
         if (tab[r].indice == 3'd0) begin
            bus.codigo = tab[r].codigo;
            bus.start  = 1'b1;
         end
         for (int c = 0; c < 7; c++) begin
            passo();
            bus.start = 1'b0;
            confere($sformatf("vet%0d_c%0d", r, c),
                    {bus.numero, bus.insere, bus.ocupado, bus.concluido, bus.indice},
                    {tab[r].numero, ((c >= 2 && c <= 4) ? 1'b0 : 1'b1), 1'b1, 1'b0, tab[r].indice});
         end
         if (tab[r].indice == 3'd5) begin
            passo();
            confere($sformatf("vet%0d_fim", r), {bus.numero, bus.insere, bus.ocupado, bus.concluido},
                    {4'h0, 1'b1, 1'b1, 1'b1});
            passo();
            confere($sformatf("vet%0d_idle", r), {bus.numero, bus.insere, bus.ocupado, bus.concluido},
                    {4'h0, 1'b1, 1'b0, 1'b0});
         end
      end
      got_q.delete();

      // Latency from acceptance to concluido, and strobed digit order.
      pulso_start(CODIGO_DEF);
      espera_fim(n);
      confere("latencia", n, 43);
      passo();
      espera_590981();
      confere_fila("basico");

      // Abort during the strobe of the third digit.
      pulso_start(24'h590981);
      n = 0;
      while (!(bus.indice == 3'd2 && bus.insere == 1'b0) && n < 100) begin
         passo();
         n++;
      end
      confere("aborto_alvo", {bus.numero, bus.indice}, {4'h0, 3'd2});
      bus.abortar = 1'b1;
      passo();
      bus.abortar = 1'b0;
      confere("aborto", {bus.numero, bus.insere, bus.ocupado, bus.concluido}, {4'h0, 1'b1, 1'b0, 1'b0});
      k = 0;
      repeat (60) begin
         passo();
         if (bus.concluido === 1'b1 || bus.ocupado === 1'b1) k++;
      end
      confere("aborto_quieto", k, 0);
      got_q.delete();
      pulso_start(24'h590981);
      confere("reinicio", {bus.numero, bus.indice, bus.ocupado}, {4'h5, 3'd0, 1'b1});
      espera_fim(n);
      confere("reinicio_lat", n, 43);
      passo();
      espera_590981();
      confere_fila("reinicio");

      // Reset in the setup phase of the fourth digit.
      pulso_start(24'h590981);
      n = 0;
      while (bus.indice != 3'd3 && n < 100) begin
         passo();
         n++;
      end
      confere("reset_alvo", {bus.numero, bus.insere}, {4'h9, 1'b1});
      reset = 1'b0;
      passo();
      confere("reset_meio", {bus.numero, bus.insere, bus.ocupado, bus.concluido, bus.indice},
              {4'h0, 1'b1, 1'b0, 1'b0, 3'd0});
      reset = 1'b1;
      passo();
      passo();
      confere("reset_idle", bus.ocupado, 1'b0);
      got_q.delete();

      // start with a different code while busy must be ignored.
      pulso_start(24'h590981);
      repeat (9) passo();
      bus.codigo = 24'h111111;
      bus.start  = 1'b1;
      repeat (20) passo();
      bus.start  = 1'b0;
      espera_fim(n);
      confere("ignora_lat", n, 14);
      passo();
      confere("ignora_idle", bus.ocupado, 1'b0);
      espera_590981();
      confere_fila("ignora");

      // start held high: second transfer relatches codigo after FIM.
      bus.codigo = 24'h590981;
      bus.start  = 1'b1;
      passo();
      espera_fim(n);
      confere("b2b_lat1", n, 43);
      bus.codigo = 24'h246813;
      passo();
      confere("b2b_idle", {bus.ocupado, bus.concluido, bus.insere}, {1'b0, 1'b0, 1'b1});
      passo();
      confere("b2b_inicio", {bus.numero, bus.ocupado, bus.indice}, {4'h2, 1'b1, 3'd0});
      bus.start = 1'b0;
      espera_fim(n);
      confere("b2b_lat2", n, 43);
      passo();
      espera_590981();
      exp_q.push_back(4'h2); exp_q.push_back(4'h4); exp_q.push_back(4'h6);
      exp_q.push_back(4'h8); exp_q.push_back(4'h1); exp_q.push_back(4'h3);
      confere_fila("b2b");

`ifdef EMISSOR_ERRO_EN
      bus.erro_idx   = 3'd1;
      bus.erro_ativo = 1'b1;
      pulso_start(24'h590981);
      bus.erro_ativo = 1'b0;
      bus.erro_idx   = 3'd0;
      espera_fim(n);
      confere("erro_lat", n, 50);
      passo();
      exp_q.push_back(4'h5); exp_q.push_back(4'h6); exp_q.push_back(4'h9);
      exp_q.push_back(4'h0); exp_q.push_back(4'h9); exp_q.push_back(4'h8);
      exp_q.push_back(4'h1);
      confere_fila("erro");
`endif

      confere("invariante", viol, 0);
      $display("%0d/%0d checks passed", passou, total);
      $finish;
   end

endmodule
